// File: rtl/seq_fsm_param.sv
// Parametrised cyclic sequencer: NUM_STATES states in one-hot, inverted one-hot
// or binary encoding, with enable/direction/load control and illegal-state recovery.
//
// state     | meaning
// ----------+-------------------------------------------------
// idx 0     | reset / wrap target when counting up
// idx 1..N-2| intermediate sequence steps
// idx N-1   | last step; leaving it upward wraps to idx 0
// illegal   | cs not a valid encoding; next enabled edge -> idx 0
module seq_fsm_param #(
  parameter int NUM_STATES = 4,
  parameter int OUT_W      = 2,
  parameter int ENCODING   = 0,
  localparam int IDX_W     = ($clog2(NUM_STATES) < 1) ? 1 : $clog2(NUM_STATES),
  localparam int ST_W      = (ENCODING == 2) ? IDX_W : NUM_STATES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  output logic [OUT_W-1:0] o,
  output logic [IDX_W-1:0] state_idx,
  output logic             wrap,
  output logic             err
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_STATES - 1);

  logic [ST_W-1:0]  cs;
  logic [ST_W-1:0]  hot;
  logic [4:0]       hot_cnt;
  logic             cur_legal;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] nxt_up;
  logic [IDX_W-1:0] nxt_dn;
  logic [OUT_W-1:0] nxt_o;
  logic             load_ok;

  function automatic logic [ST_W-1:0] enc(input logic [IDX_W-1:0] idx);
    logic [ST_W-1:0] e;
    e = '0;
    if (ENCODING == 2) begin
      e = ST_W'(idx);
    end else begin
      e = ST_W'(1) << idx;
      if (ENCODING == 1) e = ~e;
    end
    return e;
  endfunction

  // Decode the state register; illegal patterns report index 0.
  always_comb begin
    hot       = '0;
    hot_cnt   = '0;
    cur_legal = 1'b0;
    cur_idx   = '0;
    if (ENCODING == 2) begin
      cur_legal = (32'(cs) < 32'(NUM_STATES));
      cur_idx   = IDX_W'(cs);
    end else begin
      hot = (ENCODING == 1) ? ~cs : cs;
      for (int b = 0; b < ST_W; b++) begin
        if (hot[b]) begin
          hot_cnt = hot_cnt + 5'd1;
          cur_idx = IDX_W'(b);
        end
      end
      cur_legal = (hot_cnt == 5'd1);
    end
  end

  assign state_idx = cur_legal ? cur_idx : '0;

  always_comb begin
    nxt_up  = (cur_idx == LAST) ? '0 : cur_idx + 1'b1;
    nxt_dn  = (cur_idx == '0) ? LAST : cur_idx - 1'b1;
    nxt_o   = (cur_idx == LAST) ? '0 : OUT_W'(32'(cur_idx) + 32'd1);
    load_ok = (32'(load_idx) < 32'(NUM_STATES));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs   <= enc('0);
      o    <= '0;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else if (load) begin
      wrap <= 1'b0;
      if (load_ok) begin
        cs  <= enc(load_idx);
        err <= 1'b0;
      end else begin
        cs  <= enc('0);
        err <= 1'b1;
      end
    end else if (en) begin
      if (cur_legal) begin
        o   <= nxt_o;
        err <= 1'b0;
        if (!dir) begin
          cs   <= enc(nxt_up);
          wrap <= (cur_idx == LAST);
        end else begin
          cs   <= enc(nxt_dn);
          wrap <= (cur_idx == '0);
        end
      end else begin
        cs   <= enc('0);
        o    <= '0;
        wrap <= 1'b0;
        err  <= 1'b1;
      end
    end else begin
      wrap <= 1'b0;
      err  <= 1'b0;
    end
  end

endmodule
